// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter. Bytes enter a small circular FIFO over
// a valid/ready handshake. Each byte is sent as one start bit, BITS data bits
// (LSB first) and one stop bit, with no parity, at clks_per_bit clocks per bit.
// Queued frames go out back-to-back with no idle gap between them.
module uart_tx #(
    parameter int clks_per_bit = 104,
    parameter int BITS         = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tx_valid,
    output logic            tx_ready,
    input  logic [BITS-1:0] tx_data,
    output logic            tx,
    output logic            tx_active,
    output logic            tx_done
);

    localparam int CNT_W = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    localparam int IDX_W = $clog2(BITS) + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(clks_per_bit - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BITS - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // FIFO storage and control
    logic [BITS-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;

    // Serialiser state
    state_t           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [IDX_W-1:0] r_bit_idx;
    logic [BITS-1:0]  r_shift;
    logic             r_tx;

    // Next-state values
    logic             w_wr;
    logic             w_pop;
    logic             w_empty;
    logic             w_cnt_last;
    logic             w_done;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [BITS-1:0]  w_shift_nxt;
    logic             w_tx_nxt;

    assign w_empty    = (r_count == '0);
    assign w_cnt_last = (r_bit_cnt == CNT_LAST);
    assign w_wr       = tx_valid && tx_ready;

    assign tx_ready   = (r_count != OCC_FULL);
    assign tx         = r_tx;
    assign tx_active  = (r_state != S_IDLE);
    assign tx_done    = w_done;

    // FIFO payload storage; data only, so no reset
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous write and pop keeps the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // State register, bit counters and the registered line output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_bit_idx <= w_idx_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // Shift register holds the byte being sent; data only, so no reset
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    // Next-state logic; the line value is computed for the state being entered
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_idx_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_mem[r_rd_ptr];
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_START;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_cnt_nxt = r_bit_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    w_idx_nxt   = r_bit_idx + IDX_W'(1);
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_tx_nxt = w_shift_nxt[0];
                    end
                end else begin
                    w_cnt_nxt = r_bit_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (w_cnt_last) begin
                    w_done    = 1'b1;
                    w_cnt_nxt = '0;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_mem[r_rd_ptr];
                        w_idx_nxt   = '0;
                        w_state_nxt = S_START;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_bit_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Accepted bytes are queued as
// expected frames; a line monitor decodes every frame and compares it.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int BITS  = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = (BITS + 2) * CPB;
    localparam int TCLK  = 10;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready;
    logic       tx;
    logic       tx_active;
    logic       tx_done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_q [$];
    time        done_q [$];

    always #(TCLK / 2) clk = ~clk;

    uart_tx #(
        .clks_per_bit(CPB),
        .BITS        (BITS),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx       (tx),
        .tx_active(tx_active),
        .tx_done  (tx_done)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Offer a byte and hold it until accepted; returns the accepting edge time
    task automatic send(input logic [7:0] b, output time t_acc);
        int  n;
        logic rdy;
        n = 0;
        t_acc = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        forever begin
            rdy = tx_ready;
            @(posedge clk);
            if (rdy) begin
                t_acc = $time;
                exp_q.push_back(b);
                break;
            end
            n++;
            if (n > 2000) begin
                check("send_timeout", 64'(n), 64'(0));
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_active) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(n < 5000), 64'(1));
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: decodes frames at the falling clock edge, checks status pins
    initial begin : monitor
        bit         in_frame;
        bit         stable;
        int         c;
        logic       cur;
        logic [9:0] bits;
        logic [7:0] exp;
        in_frame = 1'b0;
        stable   = 1'b1;
        c        = 0;
        cur      = 1'b1;
        bits     = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 1'b0;
                continue;
            end
            if (!in_frame && tx == 1'b0) begin
                in_frame = 1'b1;
                c        = 0;
                stable   = 1'b1;
            end
            check("tx_active", 64'(tx_active), 64'(in_frame));
            if (in_frame) begin
                if (c % CPB == 0) cur = tx;
                else if (tx !== cur) stable = 1'b0;
                if (c % CPB == CPB / 2) bits[c / CPB] = tx;
                check("tx_done_frame", 64'(tx_done), 64'(c == FRAME - 1));
                if (c == FRAME - 1) begin
                    done_q.push_back($time);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %0h, expected no frame at %0t",
                                 bits[8:1], $time);
                    end else begin
                        exp = exp_q.pop_front();
                        check("frame", {53'd0, stable, bits[9], bits[0], bits[8:1]},
                              {53'd0, 1'b1, 1'b1, 1'b0, exp});
                    end
                    in_frame = 1'b0;
                end else begin
                    c++;
                end
            end else begin
                check("tx_done_idle", 64'(tx_done), 64'(0));
            end
        end
    end

    // Hard time limit so the bench always ends
    initial begin : watchdog
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        time        t_acc;
        time        t_full [6];
        int         d0;
        int         hi;
        logic [7:0] full_bytes [6];
        logic [7:0] loop_bytes [3];

        full_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hC3};
        loop_bytes = '{8'h00, 8'hFF, 8'h81};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", 64'(tx), 64'(1));
        check("rst_ready", 64'(tx_ready), 64'(1));
        check("rst_active", 64'(tx_active), 64'(0));
        check("rst_done", 64'(tx_done), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0x55: line still high after the write edge, low one edge later
        send(8'h55, t_acc);
        #1;
        check("lat_write_edge_tx", 64'(tx), 64'(1));
        @(negedge clk);
        tx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("lat_pop_edge_tx", 64'(tx), 64'(0));
        check("lat_pop_edge_active", 64'(tx_active), 64'(1));
        wait_drain();

        // Back-to-back: two done pulses exactly one frame apart
        send(8'hA5, t_acc);
        send(8'h3C, t_acc);
        go_idle();
        wait_drain();
        check("b2b_done_count", 64'(done_q.size() >= 3), 64'(1));
        if (done_q.size() >= 2)
            check("b2b_done_spacing", 64'(done_q[done_q.size() - 1] - done_q[done_q.size() - 2]),
                  64'(FRAME * TCLK));

        // FIFO full with valid held high
        d0 = done_q.size();
        for (int i = 0; i < 6; i++) begin
            send(full_bytes[i], t_full[i]);
            if (i == 4) begin
                #1;
                check("full_ready_low", 64'(tx_ready), 64'(0));
            end
        end
        go_idle();
        for (int i = 1; i < 5; i++)
            check("full_consecutive", 64'(t_full[i] - t_full[0]), 64'(i * TCLK));
        check("full_done_seen", 64'(done_q.size() > d0), 64'(1));
        if (done_q.size() > d0)
            check("full_byte5_accept", 64'(t_full[5]), 64'(done_q[d0] + 3 * TCLK / 2));
        wait_drain();

        // Loopback-style bytes, each sent from idle
        for (int i = 0; i < 3; i++) begin
            send(loop_bytes[i], t_acc);
            go_idle();
            wait_drain();
        end

        // Reset during data bit 3 with a second byte queued
        d0 = done_q.size();
        send(8'h0F, t_acc);
        send(8'hF0, t_acc);
        go_idle();
        repeat (CPB + 3 * CPB) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_tx", 64'(tx), 64'(1));
        check("midrst_ready", 64'(tx_ready), 64'(1));
        check("midrst_active", 64'(tx_active), 64'(0));
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx === 1'b1) hi++;
        end
        check("midrst_line_idle", 64'(hi), 64'(60));
        check("midrst_no_done", 64'(done_q.size()), 64'(d0));

        // Pointer wrap: ten bytes paced on tx_ready
        for (int i = 0; i < 10; i++) begin
            send(8'(i * 29 + 3), t_acc);
        end
        go_idle();
        wait_drain();
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
